// File: rtl/imem_arbiter_if.sv
// Fetch port, burst (loader/debug) port and instruction-memory port of imem_arbiter.
interface imem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_len;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_last;
    logic              d_busy;

    logic              mem_ce;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;

    logic              misalign;

    // Arbiter side.
    modport slave (
        input  f_req, f_addr, d_req, d_addr, d_len, mem_data,
        output f_gnt, f_rvalid, f_rdata,
        output d_gnt, d_rvalid, d_rdata, d_last, d_busy,
        output mem_ce, mem_addr, misalign
    );

    // Requesters plus memory side.
    modport master (
        output f_req, f_addr, d_req, d_addr, d_len, mem_data,
        input  f_gnt, f_rvalid, f_rdata,
        input  d_gnt, d_rvalid, d_rdata, d_last, d_busy,
        input  mem_ce, mem_addr, misalign
    );
endinterface

// File: rtl/imem_arbiter.sv
// Two-requester instruction-memory arbiter: single-word fetches and non-preemptible bursts.
// Define IMEM_ARB_RR_EN for round-robin on contested grants; default is fetch priority.
module imem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    imem_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] WORD_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ptr_q, ptr_d;

    logic              f_rvalid_q, f_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              d_last_q, d_last_d;
    logic              mis_q, mis_d;
    logic [31:0]       f_rdata_q, f_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    logic              f_gnt_s, d_gnt_s, burst_word_s, ce_s, last_s;
    logic [ADDR_W-1:0] maddr_s;

    function automatic logic [4:0] burst_words(input logic [3:0] len);
        burst_words = (len == 4'd0) ? 5'd16 : {1'b0, len};
    endfunction

    // Arbitration, burst sequencing and next values of the registered read path.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        ptr_d        = ptr_q;
        f_gnt_s      = 1'b0;
        d_gnt_s      = 1'b0;
        burst_word_s = 1'b0;
        ce_s         = 1'b0;
        last_s       = 1'b0;
        maddr_s      = '0;

        case (state_q)
            IDLE: begin
                if (bus.f_req && bus.d_req) begin
`ifdef IMEM_ARB_RR_EN
                    if (ptr_q == 1'b0) begin
                        f_gnt_s = 1'b1;
                    end else begin
                        d_gnt_s = 1'b1;
                    end
                    ptr_d = ~ptr_q;
`else
                    f_gnt_s = 1'b1;
`endif
                end else if (bus.f_req) begin
                    f_gnt_s = 1'b1;
                end else if (bus.d_req) begin
                    d_gnt_s = 1'b1;
                end else begin
                    f_gnt_s = 1'b0;
                end

                if (f_gnt_s) begin
                    ce_s    = 1'b1;
                    maddr_s = {bus.f_addr[ADDR_W-1:2], 2'b00};
                end else if (d_gnt_s) begin
                    ce_s    = 1'b1;
                    maddr_s = {bus.d_addr[ADDR_W-1:2], 2'b00};
                    addr_d  = maddr_s;
                    // cnt holds the words still owed after the one issued now
                    cnt_d   = burst_words(bus.d_len) - 5'd1;
                    last_s  = (cnt_d == 5'd0);
                    if (cnt_d != 5'd0) begin
                        state_d = BURST;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ce_s = 1'b0;
                end
            end

            BURST: begin
                burst_word_s = 1'b1;
                ce_s         = 1'b1;
                maddr_s      = addr_q + WORD_STEP;
                addr_d       = maddr_s;
                cnt_d        = cnt_q - 5'd1;
                last_s       = (cnt_q == 5'd1);
                if (cnt_q == 5'd1) begin
                    state_d = IDLE;
                end else begin
                    state_d = BURST;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase

        f_rvalid_d = f_gnt_s;
        d_rvalid_d = d_gnt_s | burst_word_s;
        d_last_d   = last_s;
        f_rdata_d  = f_gnt_s ? bus.mem_data : f_rdata_q;
        d_rdata_d  = (d_gnt_s | burst_word_s) ? bus.mem_data : d_rdata_q;

        if (f_gnt_s) begin
            mis_d = |bus.f_addr[1:0];
        end else if (d_gnt_s) begin
            mis_d = |bus.d_addr[1:0];
        end else begin
            mis_d = mis_q;
        end
    end

    // State, counter, pointer and read-path registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            addr_q     <= '0;
            ptr_q      <= 1'b0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_last_q   <= 1'b0;
            mis_q      <= 1'b0;
            f_rdata_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            ptr_q      <= ptr_d;
            f_rvalid_q <= f_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            d_last_q   <= d_last_d;
            mis_q      <= mis_d;
            f_rdata_q  <= f_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Grant-cycle outputs are combinational, so they are gated to force zero while reset is held.
    assign bus.f_gnt    = rst & f_gnt_s;
    assign bus.d_gnt    = rst & d_gnt_s;
    assign bus.mem_ce   = rst & ce_s;
    assign bus.mem_addr = rst ? maddr_s : '0;

    assign bus.f_rvalid = f_rvalid_q;
    assign bus.f_rdata  = f_rdata_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_last   = d_last_q;
    assign bus.d_busy   = (state_q == BURST);
    assign bus.misalign = mis_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (pending burst words kept as a queue of addresses).
module tb_imem_arbiter;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_tot;

    imem_arbiter_if #(.ADDR_W(32)) bus ();

    imem_arbiter #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0000f025;
        else if (a == 32'h4) return 32'h241d1000;
        else                 return {a[15:0] ^ 16'h5a3c, ~a[31:16]} ^ (a * 32'd2654435761);
    endfunction

    assign bus.mem_data = mem_word(bus.mem_addr);

    // ---------------- reference model ----------------
    logic [31:0] bq[$];
    bit          rr_ptr;
    bit          in_rst;
    logic        e_fg, e_dg, e_ce, e_burst;
    logic [31:0] e_ma;
    logic        e_frv, e_drv, e_dlast, e_mis;
    logic [31:0] e_frd, e_drd;

    function automatic void model_reset();
        bq.delete();
        rr_ptr = 1'b0;
        e_fg = 1'b0; e_dg = 1'b0; e_ce = 1'b0; e_burst = 1'b0; e_ma = 32'd0;
        e_frv = 1'b0; e_drv = 1'b0; e_dlast = 1'b0; e_mis = 1'b0;
        e_frd = 32'd0; e_drd = 32'd0;
    endfunction

    function automatic void model_eval();
        e_fg = 1'b0; e_dg = 1'b0; e_ce = 1'b0; e_burst = 1'b0; e_ma = 32'd0;
        if (in_rst) return;
        if (bq.size() > 0) begin
            e_burst = 1'b1;
            e_ce    = 1'b1;
            e_ma    = bq[0];
        end else begin
            if (bus.f_req && bus.d_req) begin
`ifdef IMEM_ARB_RR_EN
                if (rr_ptr == 1'b0) e_fg = 1'b1;
                else                e_dg = 1'b1;
`else
                e_fg = 1'b1;
`endif
            end else begin
                e_fg = bus.f_req;
                e_dg = bus.d_req;
            end
            if (e_fg) begin e_ce = 1'b1; e_ma = {bus.f_addr[31:2], 2'b00}; end
            if (e_dg) begin e_ce = 1'b1; e_ma = {bus.d_addr[31:2], 2'b00}; end
        end
    endfunction

    function automatic void model_commit();
        int words;
        if (in_rst) return;
        e_frv   = e_fg;
        e_drv   = e_dg || e_burst;
        e_dlast = 1'b0;
        if (e_fg) begin
            e_frd = mem_word(e_ma);
            e_mis = (bus.f_addr[1:0] != 2'd0);
        end
        if (e_dg || e_burst) e_drd = mem_word(e_ma);
        if (e_burst) begin
            void'(bq.pop_front());
            e_dlast = (bq.size() == 0);
        end
        if (e_dg) begin
            words = (bus.d_len == 4'd0) ? 16 : int'(bus.d_len);
            e_mis = (bus.d_addr[1:0] != 2'd0);
            for (int k = 1; k < words; k++) bq.push_back(e_ma + 32'(4 * k));
            e_dlast = (words == 1);
        end
        if (bus.f_req && bus.d_req && (e_fg || e_dg)) rr_ptr = ~rr_ptr;
    endfunction

    function automatic logic [103:0] obs_vec();
        return {bus.f_gnt, bus.d_gnt, bus.mem_ce, bus.mem_addr, bus.f_rvalid, bus.f_rdata,
                bus.d_rvalid, bus.d_rdata, bus.d_last, bus.d_busy, bus.misalign};
    endfunction

    function automatic logic [103:0] exp_vec();
        return {e_fg, e_dg, e_ce, e_ma, e_frv, e_frd, e_drv, e_drd, e_dlast,
                (bq.size() > 0), e_mis};
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic set_in(input logic fr, input logic [31:0] fa, input logic dr,
                          input logic [31:0] da, input logic [3:0] dl);
        bus.f_req = fr; bus.f_addr = fa; bus.d_req = dr; bus.d_addr = da; bus.d_len = dl;
    endtask

    task automatic to_mid();
        model_eval();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(posedge clk); #1;
        set_in(1'b1, 32'h10, 1'b1, 32'h40, 4'd2);
        for (int i = 0; i < 3; i++) begin
            to_mid();
            n_tot++;
            if (obs_vec() !== 104'd0) $display("FAIL reset_outputs c%0d got %h want 0", i, obs_vec());
            else n_pass++;
            adv();
        end
        rst = 1'b1; in_rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
    endtask

    task automatic test_fetch();
        logic [31:0] fa [2] = '{32'h0, 32'h4};
        logic [31:0] fw [2] = '{32'h0000f025, 32'h241d1000};
        for (int i = 0; i < 4; i++) begin
            if (i < 2) set_in(1'b1, fa[i], 1'b0, 32'h0, 4'd0);
            else       set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
            to_mid();
            n_tot++;
            if (obs_vec() !== exp_vec()) $display("FAIL fetch_model c%0d got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i < 2) begin
                n_tot++;
                if (bus.f_gnt !== 1'b1 || bus.mem_addr !== fa[i] || bus.mem_ce !== 1'b1)
                    $display("FAIL fetch_gnt c%0d got gnt=%b addr=%h want gnt=1 addr=%h", i, bus.f_gnt, bus.mem_addr, fa[i]);
                else n_pass++;
            end
            if (i >= 1 && i <= 2) begin
                n_tot++;
                if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== fw[i-1])
                    $display("FAIL fetch_data c%0d got rv=%b data=%h want rv=1 data=%h", i, bus.f_rvalid, bus.f_rdata, fw[i-1]);
                else n_pass++;
            end else if (i == 3) begin
                n_tot++;
                if (bus.f_rvalid !== 1'b0 || bus.f_rdata !== 32'h241d1000 || bus.mem_addr !== 32'h0)
                    $display("FAIL fetch_hold got rv=%b data=%h addr=%h want rv=0 data=241d1000 addr=0", bus.f_rvalid, bus.f_rdata, bus.mem_addr);
                else n_pass++;
            end
            adv();
        end
    endtask

    task automatic test_burst();
        logic [31:0] addrs[$];
        int nrv = 0, nlast = 0, nbusy = 0, ngnt = 0, last_idx = -1;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 32'h0, (i == 0), 32'h20, 4'd3);
            to_mid();
            n_tot++;
            if (obs_vec() !== exp_vec()) $display("FAIL burst_model c%0d got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (bus.mem_ce === 1'b1) addrs.push_back(bus.mem_addr);
            if (bus.d_rvalid === 1'b1) nrv++;
            if (bus.d_last === 1'b1) begin nlast++; last_idx = nrv; end
            if (bus.d_busy === 1'b1) nbusy++;
            if (bus.d_gnt === 1'b1) ngnt++;
            adv();
        end
        n_tot++;
        if (addrs.size() != 3 || addrs[0] !== 32'h20 || addrs[1] !== 32'h24 || addrs[2] !== 32'h28)
            $display("FAIL burst_addrs got %0d accesses want 3 at 20,24,28", addrs.size());
        else n_pass++;
        n_tot++;
        if (nrv != 3 || nlast != 1 || last_idx != 3)
            $display("FAIL burst_rvalid got rv=%0d last=%0d at %0d want rv=3 last=1 at 3", nrv, nlast, last_idx);
        else n_pass++;
        n_tot++;
        if (nbusy != 2 || ngnt != 1) $display("FAIL burst_busy got busy=%0d gnt=%0d want busy=2 gnt=1", nbusy, ngnt);
        else n_pass++;
    endtask

    task automatic test_preempt();
        int first_fg = -1, nrv = 0;
        for (int i = 0; i < 20; i++) begin
            set_in((i >= 1 && i < 18), 32'h200, (i == 0), 32'h100, 4'd0);
            to_mid();
            n_tot++;
            if (obs_vec() !== exp_vec()) $display("FAIL preempt_model c%0d got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (bus.f_gnt === 1'b1 && first_fg < 0) first_fg = i;
            if (bus.d_rvalid === 1'b1) nrv++;
            adv();
        end
        n_tot++;
        if (first_fg != 16 || nrv != 16) $display("FAIL preempt_wait got first_fgnt=%0d rv=%0d want 16 and 16", first_fg, nrv);
        else n_pass++;
    endtask

    task automatic test_contest();
        int nf = 0, nd = 0;
        for (int i = 0; i < 11; i++) begin
            set_in((i < 8), 32'h300, (i < 8), 32'h380, 4'd2);
            to_mid();
            n_tot++;
            if (obs_vec() !== exp_vec()) $display("FAIL contest_model c%0d got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (bus.f_gnt === 1'b1) nf++;
            if (bus.d_gnt === 1'b1) nd++;
            adv();
        end
        n_tot++;
`ifdef IMEM_ARB_RR_EN
        if (nf != 3 || nd != 3) $display("FAIL contest_share got f=%0d d=%0d want 3 and 3", nf, nd);
        else n_pass++;
`else
        if (nf != 8 || nd != 0) $display("FAIL contest_prio got f=%0d d=%0d want 8 and 0", nf, nd);
        else n_pass++;
`endif
    endtask

    task automatic test_misalign();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       set_in(1'b1, 32'h6, 1'b0, 32'h0, 4'd0);
                1:       set_in(1'b1, 32'h8, 1'b0, 32'h0, 4'd0);
                2:       set_in(1'b0, 32'h0, 1'b1, 32'h31, 4'd1);
                default: set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
            endcase
            to_mid();
            n_tot++;
            if (obs_vec() !== exp_vec()) $display("FAIL misalign_model c%0d got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            n_tot++;
            case (i)
                0: if (bus.mem_addr !== 32'h4) $display("FAIL misalign_addr got %h want 4", bus.mem_addr); else n_pass++;
                1: if (bus.misalign !== 1'b1) $display("FAIL misalign_set got %b want 1", bus.misalign); else n_pass++;
                2: if (bus.misalign !== 1'b0 || bus.mem_addr !== 32'h30)
                       $display("FAIL misalign_clear got mis=%b addr=%h want 0 and 30", bus.misalign, bus.mem_addr);
                   else n_pass++;
                default: if (bus.misalign !== 1'b1) $display("FAIL misalign_burst c%0d got %b want 1", i, bus.misalign); else n_pass++;
            endcase
            adv();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[$];
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 32'h0, (i == 0), 32'hFFFF_FFF8, 4'd4);
            to_mid();
            n_tot++;
            if (obs_vec() !== exp_vec()) $display("FAIL wrap_model c%0d got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (bus.mem_ce === 1'b1) addrs.push_back(bus.mem_addr);
            adv();
        end
        n_tot++;
        if (addrs.size() != 4 || addrs[0] !== 32'hFFFF_FFF8 || addrs[1] !== 32'hFFFF_FFFC ||
            addrs[2] !== 32'h0 || addrs[3] !== 32'h4)
            $display("FAIL wrap_addrs got %0d accesses want 4 at fffffff8,fffffffc,0,4", addrs.size());
        else n_pass++;
    endtask

    task automatic test_reset_midburst();
        int nrv = 0;
        set_in(1'b0, 32'h0, 1'b1, 32'h400, 4'd4);
        to_mid();
        n_tot++;
        if (obs_vec() !== exp_vec()) $display("FAIL rstmid_model c0 got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        adv();
        set_in(1'b1, 32'h800, 1'b0, 32'h0, 4'd0);
        to_mid();
        n_tot++;
        if (bus.mem_addr !== 32'h404 || bus.d_busy !== 1'b1)
            $display("FAIL rstmid_word2 got addr=%h busy=%b want 404 and 1", bus.mem_addr, bus.d_busy);
        else n_pass++;
        #1 rst = 1'b0; in_rst = 1'b1; model_reset();
        #1;
        n_tot++;
        if (obs_vec() !== 104'd0) $display("FAIL rstmid_async got %h want 0", obs_vec());
        else n_pass++;
        adv();
        for (int i = 0; i < 2; i++) begin
            to_mid();
            n_tot++;
            if (obs_vec() !== exp_vec()) $display("FAIL rstmid_hold c%0d got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (bus.d_rvalid !== 1'b0) nrv++;
            adv();
        end
        rst = 1'b1; in_rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b1, 32'h500, 4'd1);
        to_mid();
        n_tot++;
        if (bus.d_gnt !== 1'b1 || bus.mem_addr !== 32'h500 || obs_vec() !== exp_vec())
            $display("FAIL rstmid_regrant got gnt=%b addr=%h want gnt=1 addr=500", bus.d_gnt, bus.mem_addr);
        else n_pass++;
        adv();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        to_mid();
        n_tot++;
        if (bus.d_rvalid !== 1'b1 || bus.d_last !== 1'b1 || bus.d_rdata !== mem_word(32'h500) || nrv != 0)
            $display("FAIL rstmid_single got rv=%b last=%b data=%h stray=%0d want 1 1 %h 0",
                     bus.d_rvalid, bus.d_last, bus.d_rdata, nrv, mem_word(32'h500));
        else n_pass++;
        adv();
    endtask

    task automatic test_random();
        for (int i = 0; i < 420; i++) begin
            if (i < 400)
                set_in(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0), $urandom,
                       4'($urandom_range(0, 15)));
            else
                set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
            to_mid();
            n_tot++;
            if (obs_vec() !== exp_vec()) $display("FAIL random_model c%0d got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            adv();
        end
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        rst    = 1'b0;
        in_rst = 1'b1;
        model_reset();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        test_reset();
        test_fetch();
        test_burst();
        test_preempt();
        test_contest();
        test_misalign();
        test_wrap();
        test_reset_midburst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
